// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the instruction-memory loader.
// master = byte source, slave = loader.
interface imem_loader_if;
    logic [7:0] byteIn;
    logic       byteValid;
    logic       byteReady;

    modport master (output byteIn, output byteValid, input byteReady);
    modport slave  (input byteIn, input byteValid, output byteReady);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed big-endian byte stream into 16-bit
// instruction-memory writes, holding the CPU until the image is complete.
module imem_loader #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          DEPTH_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    imem_loader_if.slave       bs,
    output logic [15:0]        writeAddress,
    output logic [15:0]        writeData,
    output logic               writeEnable,
    output logic               cpuHold,
    output logic               done,
    output logic               error,
    output logic [15:0]        wordsWritten
);
    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
    } state_t;

    state_t      state_reg;
    logic [15:0] len_reg;
    logic [15:0] count_reg;
    logic [15:0] addr_reg;
    logic [15:0] data_reg;
    logic [7:0]  hi_reg;
    logic        we_reg;
    logic        hold_reg;
    logic        done_reg;
    logic        err_reg;
    logic        xfer;
    logic [15:0] len_next;

    // Ready depends only on state so the source never sees a combinational loop.
    assign bs.byteReady = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                          (state_reg == DATA_HI) || (state_reg == DATA_LO);
    assign xfer     = bs.byteValid && bs.byteReady;
    assign len_next = {len_reg[15:8], bs.byteIn};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            len_reg   <= 16'h0000;
            count_reg <= 16'h0000;
            addr_reg  <= 16'h0000;
            data_reg  <= 16'h0000;
            hi_reg    <= 8'h00;
            we_reg    <= 1'b0;
            hold_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_reg <= LEN_HI;
                        count_reg <= 16'h0000;
                        done_reg  <= 1'b0;
                        err_reg   <= 1'b0;
                        hold_reg  <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_reg[15:8] <= bs.byteIn;
                        state_reg     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_reg[7:0] <= bs.byteIn;
                        if (len_next == 16'h0000) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            hold_reg  <= 1'b0;
                        end else if ({1'b0, len_next} > DEPTH_L) begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end else begin
                            state_reg <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi_reg    <= bs.byteIn;
                        state_reg <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    // Address and data are registered here so they are stable for the whole WRITE cycle.
                    if (xfer) begin
                        addr_reg  <= BASE_ADDR + count_reg;
                        data_reg  <= {hi_reg, bs.byteIn};
                        we_reg    <= 1'b1;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    count_reg <= count_reg + 16'd1;
                    if (count_reg + 16'd1 == len_reg) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        hold_reg  <= 1'b0;
                    end else begin
                        state_reg <= DATA_HI;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign writeAddress = addr_reg;
    assign writeData    = data_reg;
    assign writeEnable  = we_reg;
    assign cpuHold      = hold_reg;
    assign done         = done_reg;
    assign error        = err_reg;
    assign wordsWritten = count_reg;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, negedge
// monitors pop and compare every writeEnable pulse.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    imem_loader_if bs0 ();
    imem_loader_if bs1 ();

    logic [15:0] wa0, wd0, ww0, wa1, wd1, ww1;
    logic        we0, hold0, done0, err0, we1, hold1, done1, err1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t q0[$];
    wr_t q1[$];

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(16'h0000), .DEPTH_WORDS(256)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .bs(bs0),
        .writeAddress(wa0), .writeData(wd0), .writeEnable(we0),
        .cpuHold(hold0), .done(done0), .error(err0), .wordsWritten(ww0)
    );

    // Second instance: wrap-around base address and a tiny depth to hit N == DEPTH_WORDS.
    imem_loader #(.BASE_ADDR(16'hFFFF), .DEPTH_WORDS(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bs(bs1),
        .writeAddress(wa1), .writeData(wd1), .writeEnable(we1),
        .cpuHold(hold1), .done(done1), .error(err1), .wordsWritten(ww1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon0
        wr_t e;
        if (we0 === 1'b1) begin
            $display("dut0 write addr=%h data=%h", wa0, wd0);
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut0_unexpected_write actual=%h:%h required=none", wa0, wd0);
            end else begin
                e = q0.pop_front();
                chk("dut0_write", {wa0, wd0}, {e.a, e.d});
            end
        end
    end

    always @(negedge clk) begin : mon1
        wr_t e;
        if (we1 === 1'b1) begin
            $display("dut1 write addr=%h data=%h", wa1, wd1);
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_write actual=%h:%h required=none", wa1, wd1);
            end else begin
                e = q1.pop_front();
                chk("dut1_write", {wa1, wd1}, {e.a, e.d});
            end
        end
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? bs0.byteReady : bs1.byteReady;
    endfunction

    task automatic set_valid(input int d, input logic v);
        if (d == 0) bs0.byteValid = v;
        else        bs1.byteValid = v;
    endtask

    task automatic send(input int d, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        if (d == 0) begin bs0.byteIn = b; bs0.byteValid = 1'b1; end
        else        begin bs1.byteIn = b; bs1.byteValid = 1'b1; end
        while (rdy(d) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rdy(d) !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready_low required=ready_high byte=%h", b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        set_valid(d, 1'b0);
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        set_valid(d, 1'b0);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic chk_reset(input int d);
        if (d == 0) begin
            chk("rst0_ready", 32'(bs0.byteReady), 32'd0);
            chk("rst0_we",    32'(we0),   32'd0);
            chk("rst0_addr",  32'(wa0),   32'd0);
            chk("rst0_data",  32'(wd0),   32'd0);
            chk("rst0_words", 32'(ww0),   32'd0);
            chk("rst0_flags", {29'd0, done0, err0, hold0}, 32'd1);
        end else begin
            chk("rst1_ready", 32'(bs1.byteReady), 32'd0);
            chk("rst1_addr",  32'(wa1),   32'd0);
            chk("rst1_flags", {28'd0, we1, done1, err1, hold1}, 32'd1);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bs0.byteIn = 8'h00; bs0.byteValid = 1'b0;
        bs1.byteIn = 8'h00; bs1.byteValid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b1;

        // Back-to-back two-word load
        pulse_start(0);
        chk("t1_ready_after_start", 32'(bs0.byteReady), 32'd1);
        q0.push_back('{16'h0000, 16'h1234});
        q0.push_back('{16'h0001, 16'hABCD});
        send(0, 8'h00); send(0, 8'h02); send(0, 8'h12);
        send(0, 8'h34); send(0, 8'hAB); send(0, 8'hCD);
        bs0.byteValid = 1'b0;
        @(negedge clk);
        chk("t1_done_during_write", 32'(done0), 32'd0);
        @(negedge clk);
        chk("t1_done", 32'(done0), 32'd1);
        chk("t1_hold", 32'(hold0), 32'd0);
        chk("t1_words", 32'(ww0), 32'd2);
        chk("t1_ready_done", 32'(bs0.byteReady), 32'd0);

        // Throttled source, one word
        pulse_start(0);
        q0.push_back('{16'h0000, 16'h5AA5});
        idle(0); send(0, 8'h00);
        idle(0); send(0, 8'h01);
        idle(0); send(0, 8'h5A);
        idle(0); send(0, 8'hA5);
        bs0.byteValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_done", 32'(done0), 32'd1);
        chk("t2_words", 32'(ww0), 32'd1);

        // Empty image
        pulse_start(0);
        send(0, 8'h00); send(0, 8'h00);
        bs0.byteValid = 1'b0;
        @(negedge clk);
        chk("t3_done", 32'(done0), 32'd1);
        chk("t3_hold", 32'(hold0), 32'd0);
        chk("t3_words", 32'(ww0), 32'd0);

        // Oversize header, then recovery
        pulse_start(0);
        send(0, 8'h01); send(0, 8'h01);
        bs0.byteValid = 1'b0;
        @(negedge clk);
        chk("t4_error", 32'(err0), 32'd1);
        chk("t4_hold", 32'(hold0), 32'd1);
        chk("t4_ready", 32'(bs0.byteReady), 32'd0);
        chk("t4_done", 32'(done0), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_error_held", 32'(err0), 32'd1);
        pulse_start(0);
        chk("t4_error_cleared", 32'(err0), 32'd0);
        q0.push_back('{16'h0000, 16'hBEEF});
        send(0, 8'h00); send(0, 8'h01); send(0, 8'hBE); send(0, 8'hEF);
        bs0.byteValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_reload_done", {30'd0, done0, err0}, 32'd2);

        // Reset in the middle of a three-word load
        pulse_start(0);
        q0.push_back('{16'h0000, 16'h1111});
        send(0, 8'h00); send(0, 8'h03); send(0, 8'h11); send(0, 8'h11);
        send(0, 8'h22);
        pulse_start(0);
        chk("t5_start_ignored_ready", 32'(bs0.byteReady), 32'd1);
        chk("t5_start_ignored_words", 32'(ww0), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset(0);
        rst = 1'b1;
        pulse_start(0);
        q0.push_back('{16'h0000, 16'h7788});
        send(0, 8'h00); send(0, 8'h01); send(0, 8'h77); send(0, 8'h88);
        bs0.byteValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_reload_done", 32'(done0), 32'd1);

        // Address wrap-around, N == DEPTH_WORDS, then N > DEPTH_WORDS
        pulse_start(1);
        q1.push_back('{16'hFFFF, 16'h0102});
        q1.push_back('{16'h0000, 16'h0304});
        send(1, 8'h00); send(1, 8'h02); send(1, 8'h01);
        send(1, 8'h02); send(1, 8'h03); send(1, 8'h04);
        bs1.byteValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_done", 32'(done1), 32'd1);
        chk("t6_words", 32'(ww1), 32'd2);
        pulse_start(1);
        send(1, 8'h00); send(1, 8'h03);
        bs1.byteValid = 1'b0;
        @(negedge clk);
        chk("t6_error", 32'(err1), 32'd1);

        repeat (3) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
